// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter: two-port round-robin arbiter that turns line requests
// into four-beat memory bursts (write-back or fill) and steers read returns
// back to the granted requester through an RD_LAT-deep return tracker.
module line_fill_arbiter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        wack0,
  output logic        wack1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        done0,
  output logic        done1,
  output logic [1:0]  beat,
  output logic [1:0]  rbeat,
  output logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall,
  input  logic        mem_err,
  output logic        err
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LINE_W = 13;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned PIPE_W = BEAT_W * RD_LAT;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(3);

  // Burst control state
  logic [1:0]        state_q, state_d;
  logic              port_q,  port_d;   // port owning the current burst
  logic              ptr_q,   ptr_d;    // round-robin preference
  logic              we_q,    we_d;
  logic [LINE_W-1:0] line_q,  line_d;
  logic [BEAT_W-1:0] beat_q,  beat_d;
  logic              err_q,   err_d;

  // Read-return tracker: valid bits and beat indices shifted once per cycle
  logic [RD_LAT-1:0] rv_q, rv_d;
  logic [PIPE_W-1:0] rb_q, rb_d;

  logic              any_req;
  logic              pick;
  logic [ADDR_W-1:0] pick_addr;
  logic              in_idle;
  logic              in_issue;
  logic              accept;
  logic              acc_rd;
  logic              head_vld;
  logic [BEAT_W-1:0] head_beat;
  logic              unused_addr_bits;

  // Arbitration: the pointer breaks ties, a lone request always wins
  assign any_req   = req0 | req1;
  assign pick      = (req0 & req1) ? ptr_q : req1;
  assign pick_addr = pick ? addr1 : addr0;
  assign unused_addr_bits = ^pick_addr[2:0];

  assign in_idle   = (state_q == ST_IDLE);
  assign in_issue  = (state_q == ST_ISSUE);
  assign accept    = in_issue & ~mem_stall;
  assign acc_rd    = accept & ~we_q;

  assign head_vld  = rv_q[RD_LAT-1];
  assign head_beat = rb_q[PIPE_W-1 -: BEAT_W];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      port_q  <= 1'b0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      rv_q    <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rb_q    <= rb_d;
    end
  end

  // Next-state logic for the burst sequencer and sticky error
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    line_d  = line_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          port_d  = pick;
          we_d    = pick ? we1 : we0;
          line_d  = pick_addr[ADDR_W-1:3];
          beat_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_err) begin
          err_d = 1'b1;
        end
        if (!mem_stall) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = we_q ? ST_DONE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (mem_err) begin
          err_d = 1'b1;
        end
        if (head_vld && (head_beat == LAST_BEAT)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = ~port_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Return tracker shifts every cycle so returns ignore later stalls
  always_comb begin
    rv_d = RD_LAT'({rv_q, acc_rd});
    rb_d = PIPE_W'({rb_q, (acc_rd ? beat_q : BEAT_W'(0))});
  end

  // Output decode: requester handshakes and memory command
  always_comb begin
    logic gnt_on;
    logic gnt_port;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    wack0       = 1'b0;
    wack1       = 1'b0;
    rvalid0     = 1'b0;
    rvalid1     = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    rbeat       = '0;
    rdata       = '0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;

    gnt_on   = ~in_idle | any_req;
    gnt_port = in_idle ? pick : port_q;
    gnt0     = gnt_on & ~gnt_port;
    gnt1     = gnt_on &  gnt_port;

    wack0    = accept & we_q & ~port_q;
    wack1    = accept & we_q &  port_q;

    rvalid0  = head_vld & ~port_q;
    rvalid1  = head_vld &  port_q;
    if (head_vld) begin
      rbeat = head_beat;
      rdata = mem_data_out;
    end

    done0    = (state_q == ST_DONE) & ~port_q;
    done1    = (state_q == ST_DONE) &  port_q;

    if (in_issue) begin
      mem_addr = {line_q, beat_q, 1'b0};
      mem_rd   = ~we_q;
      mem_wr   = we_q;
      if (we_q) begin
        mem_data_in = DATA_W'(port_q ? wdata1 : wdata0);
      end
    end
  end

  assign beat = beat_q;
  assign err  = err_q;

  // Memory strobes are mutually exclusive
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_rd && mem_wr));

endmodule

// File: doc/line_fill_arbiter.md
LINE_FILL_ARBITER -- requirements
Module: line_fill_arbiter

Interface
REQ-001 SHALL have parameter: RD_LAT, default 2, cycles from an accepted memory read issue to its data on mem_data_out.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports per requester p in {0,1}: req<p>  input  1  line-burst request, held until done<p>.
REQ-005 SHALL have ports: we<p>  input  1  burst type, 1=write-back, 0=fill; sampled at grant.
REQ-006 SHALL have ports: addr<p>  input  16  line address; bits [2:0] ignored; sampled at grant.
REQ-007 SHALL have ports: wdata<p>  input  16  write word for the beat currently shown on beat.
REQ-008 SHALL have ports: gnt<p>  output  1  high from grant cycle through done cycle inclusive.
REQ-009 SHALL have ports: wack<p>  output  1  current write beat accepted by memory this cycle.
REQ-010 SHALL have ports: rvalid<p>  output  1  rdata holds a fill word this cycle.
REQ-011 SHALL have ports: done<p>  output  1  one-cycle burst completion pulse.
REQ-012 SHALL have ports: beat  output  2  index of beat being issued; rbeat  output  2  index of word on rdata; rdata  output  16  fill word (combinational from mem_data_out).
REQ-013 SHALL have memory ports: mem_addr  output  16; mem_data_in  output  16; mem_rd  output  1; mem_wr  output  1; mem_data_out  input  16; mem_stall  input  1; mem_err  input  1.
REQ-014 SHALL have port: err  output  1  sticky memory-error flag.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: if any req high, SHALL grant one requester, latch we/addr[15:3], set beat=0, go ISSUE next cycle; gnt asserted in the grant cycle.
REQ-017 Arbitration SHALL be round-robin: pointer resets to port 0; on simultaneous requests the pointer's port wins; after each DONE the pointer moves to the non-served port.
REQ-018 A lone request SHALL be granted regardless of pointer.
REQ-019 ISSUE: SHALL drive mem_addr={latched addr[15:3], beat, 1'b0}, mem_rd=~we, mem_wr=we, mem_data_in=wdata of granted port (0 for reads).
REQ-020 An issue is accepted when mem_stall=0; beat SHALL advance only on acceptance; while stalled, address/data/strobes SHALL hold.
REQ-021 wack<p> SHALL equal granted & we & ISSUE & ~mem_stall.
REQ-022 After beat 3 is accepted: write bursts SHALL go to DONE; read bursts SHALL go to DRAIN.
REQ-023 Read return SHALL be tracked by an RD_LAT-deep valid/beat-index pipeline fed by accepted reads; rvalid<p> and rbeat SHALL assert exactly RD_LAT cycles after each accepted read, regardless of later stalls.
REQ-024 DRAIN: mem_rd=mem_wr=0; SHALL go to DONE in the cycle the beat-3 word is delivered (rvalid with rbeat=3), so done follows the last word by one cycle.
REQ-025 DONE: done<p>=1 for one cycle, gnt still high, no memory strobes; next state IDLE; new grant earliest the following cycle.
REQ-026 Deassertion of req mid-burst SHALL NOT abort the burst.
REQ-027 Non-granted port SHALL see gnt, wack, rvalid, done all 0.
REQ-028 mem_addr, mem_data_in SHALL be 0 outside ISSUE.
REQ-029 err SHALL set when mem_err=1 while in ISSUE or DRAIN and hold until reset; bursts complete normally.
REQ-030 At most one of mem_rd, mem_wr SHALL be high in any cycle.

Reset
REQ-031 With rst=1 at an edge: state IDLE, pointer port 0, beat 0, read pipeline cleared, err 0.
REQ-032 While in IDLE after reset, all outputs SHALL be 0.
REQ-033 Reset mid-burst SHALL abandon the burst: no done, no further rvalid from in-flight reads.

Verification
REQ-034 Port 0 fill, addr 0x1234, no stalls -> mem_addr 0x1230,0x1232,0x1234,0x1236 on consecutive cycles; rvalid0 with rbeat 0..3 at issue+2; done0 one cycle after rbeat=3.
REQ-035 Both req same cycle after reset, port1 we=1 addr 0x0040 -> port 0 served first, then port 1: four mem_wr beats 0x0040..0x0046 with wack1 each, done1 at the cycle after beat 3 accepted.
REQ-036 Port 0 fill with mem_stall=1 for 3 cycles on beat 1 -> mem_addr holds 0x..2 for 4 cycles, beat 2 not issued early, four rvalid0 total, rbeat order 0,1,2,3.
REQ-037 mem_err pulsed during DRAIN -> err=1 and remains 1 after done and through further bursts until rst.
REQ-038 rst asserted one cycle after beat 1 accepted on a fill -> next cycle IDLE, no rvalid0, no done0; re-request completes cleanly.
